// File: rtl/coleco_ctrl_pkg.sv
// rtl/coleco_ctrl_pkg.sv - shared constants and types for the controller port emulator
// Purpose: keypad encoding table, key index constants and spinner FSM state type.
// Ports: none (package).
package coleco_ctrl_pkg;

  localparam logic [3:0] KEY_STAR     = 4'd10;
  localparam logic [3:0] KEY_HASH     = 4'd11;
  localparam logic [3:0] KEY_IDX_NONE = 4'd15;
  localparam logic [3:0] KEYCODE_NONE = 4'hF;

  // Active-low {p4,p3,p2,p1} per key index; entry 0 is the rightmost element.
  // Left to right: #, *, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0.
  localparam logic [11:0][3:0] KEYCODE_TBL = {
    4'h6, 4'h9, 4'hB, 4'h1, 4'h5, 4'hE,
    4'h3, 4'h2, 4'hC, 4'h7, 4'hD, 4'hA
  };

  typedef enum logic {
    SPIN_IDLE = 1'b0,
    SPIN_STEP = 1'b1
  } spin_state_t;

  function automatic logic [3:0] keycode(input logic [3:0] idx);
    if (idx <= KEY_HASH) begin
      return KEYCODE_TBL[idx];
    end
    return KEYCODE_NONE;
  endfunction

endpackage

// File: rtl/coleco_spinner_quad.sv
// rtl/coleco_spinner_quad.sv - quadrature spinner step generator
// Purpose: emits |delta| quadrature steps on A/B, one every SPIN_DIV clocks.
// Ports: clk, rst (sync, active high), spin_load/spin_delta (signed step count),
//        spa/spb (quadrature A/B), busy (steps remain).
module coleco_spinner_quad
  import coleco_ctrl_pkg::*;
#(
  parameter int SPIN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spin_load,
  input  logic [7:0] spin_delta,
  output logic       spa,
  output logic       spb,
  output logic       busy
);

  localparam int DIV_W = (SPIN_DIV > 2) ? $clog2(SPIN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPIN_DIV - 1);

  spin_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       remain_q, remain_d;
  logic             dir_neg_q, dir_neg_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic [7:0]       delta_mag;

  always_comb begin
    // Two's-complement magnitude; -128 maps to 8'h80 = 128 steps.
    delta_mag = spin_delta[7] ? (~spin_delta + 8'd1) : spin_delta;
    state_d   = state_q;
    div_d     = div_q;
    remain_d  = remain_q;
    dir_neg_d = dir_neg_q;
    a_d       = a_q;
    b_d       = b_q;
    if (spin_load) begin
      // A reload only restarts the count; A/B keep their current phase.
      remain_d  = delta_mag;
      dir_neg_d = spin_delta[7];
      div_d     = '0;
      state_d   = (delta_mag == 8'd0) ? SPIN_IDLE : SPIN_STEP;
    end else if (state_q == SPIN_STEP) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        // Forward walk 00->10->11->01 is A'=~B, B'=A; reverse is its inverse.
        a_d      = dir_neg_q ? b_q : ~b_q;
        b_d      = dir_neg_q ? ~a_q : a_q;
        remain_d = remain_q - 8'd1;
        if (remain_q == 8'd1) begin
          state_d = SPIN_IDLE;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SPIN_IDLE;
      div_q     <= '0;
      remain_q  <= 8'd0;
      dir_neg_q <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      remain_q  <= remain_d;
      dir_neg_q <= dir_neg_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  assign spa  = a_q;
  assign spb  = b_q;
  assign busy = (state_q == SPIN_STEP);

endmodule

// File: rtl/coleco_ctrl_port_emu.sv
// rtl/coleco_ctrl_port_emu.sv - ColecoVision controller port device-side emulator
// Purpose: answers the console's joystick/keypad segment strobes from host state
//          and generates spinner quadrature.
// Ports: clk, rst (sync, active high); pin5_key_sel_n/pin8_joy_sel_n console strobes;
//        joy_dir, fire_btn, arm_btn, key_idx/key_load, spin_delta/spin_load host side;
//        pin_data_n, pin6_n, pin7_spa, pin9_spb, spin_busy to console/host.
module coleco_ctrl_port_emu
  import coleco_ctrl_pkg::*;
#(
  parameter int SPIN_DIV    = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin5_key_sel_n,
  input  logic       pin8_joy_sel_n,
  input  logic [3:0] joy_dir,
  input  logic       fire_btn,
  input  logic       arm_btn,
  input  logic [3:0] key_idx,
  input  logic       key_load,
  input  logic [7:0] spin_delta,
  input  logic       spin_load,
  output logic [3:0] pin_data_n,
  output logic       pin6_n,
  output logic       pin7_spa,
  output logic       pin9_spb,
  output logic       spin_busy
);

  logic [SYNC_STAGES-1:0] joy_sync_q, joy_sync_d;
  logic [SYNC_STAGES-1:0] key_sync_q, key_sync_d;
  logic [3:0]             key_q, key_d;
  logic [3:0]             data_q, data_d;
  logic                   pin6_q, pin6_d;

  always_comb begin
    joy_sync_d = {joy_sync_q[SYNC_STAGES-2:0], pin8_joy_sel_n};
    key_sync_d = {key_sync_q[SYNC_STAGES-2:0], pin5_key_sel_n};
    key_d      = key_load ? key_idx : key_q;
    // Start released and AND in each selected segment, like the wired-AND
    // of two commons pulled low together on a real controller.
    data_d = 4'hF;
    pin6_d = 1'b1;
    if (!joy_sync_q[SYNC_STAGES-1]) begin
      data_d = data_d & ~joy_dir;
      pin6_d = pin6_d & ~fire_btn;
    end
    if (!key_sync_q[SYNC_STAGES-1]) begin
      data_d = data_d & keycode(key_q);
      pin6_d = pin6_d & ~arm_btn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      joy_sync_q <= '1;
      key_sync_q <= '1;
      key_q      <= KEY_IDX_NONE;
      data_q     <= 4'hF;
      pin6_q     <= 1'b1;
    end else begin
      joy_sync_q <= joy_sync_d;
      key_sync_q <= key_sync_d;
      key_q      <= key_d;
      data_q     <= data_d;
      pin6_q     <= pin6_d;
    end
  end

  assign pin_data_n = data_q;
  assign pin6_n     = pin6_q;

  coleco_spinner_quad #(
    .SPIN_DIV(SPIN_DIV)
  ) u_spinner (
    .clk       (clk),
    .rst       (rst),
    .spin_load (spin_load),
    .spin_delta(spin_delta),
    .spa       (pin7_spa),
    .spb       (pin9_spb),
    .busy      (spin_busy)
  );

endmodule

// File: tb/tb_coleco_ctrl_port_emu.sv
// tb/tb_coleco_ctrl_port_emu.sv - scoreboard bench for coleco_ctrl_port_emu
module tb_coleco_ctrl_port_emu;

  localparam int SD  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pin5_key_sel_n = 1'b1;
  logic       pin8_joy_sel_n = 1'b1;
  logic [3:0] joy_dir = 4'h0;
  logic       fire_btn = 1'b0;
  logic       arm_btn = 1'b0;
  logic [3:0] key_idx = 4'h0;
  logic       key_load = 1'b0;
  logic [7:0] spin_delta = 8'h00;
  logic       spin_load = 1'b0;
  logic [3:0] pin_data_n;
  logic       pin6_n;
  logic       pin7_spa;
  logic       pin9_spb;
  logic       spin_busy;

  coleco_ctrl_port_emu #(
    .SPIN_DIV(SD),
    .SYNC_STAGES(SS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pin5_key_sel_n(pin5_key_sel_n),
    .pin8_joy_sel_n(pin8_joy_sel_n),
    .joy_dir       (joy_dir),
    .fire_btn      (fire_btn),
    .arm_btn       (arm_btn),
    .key_idx       (key_idx),
    .key_load      (key_load),
    .spin_delta    (spin_delta),
    .spin_load     (spin_load),
    .pin_data_n    (pin_data_n),
    .pin6_n        (pin6_n),
    .pin7_spa      (pin7_spa),
    .pin9_spb      (pin9_spb),
    .spin_busy     (spin_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observed vector: {busy, A, B, pin6_n, pin_data_n[3:0]}
  typedef struct {
    int         at;
    string      name;
    logic [7:0] val;
    logic [7:0] mask;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] kc_tbl [16] = '{4'hA, 4'hD, 4'h7, 4'hC, 4'h2, 4'h3, 4'hE, 4'h5,
                              4'h1, 4'hB, 4'h9, 4'h6, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [1:0] ab_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int key_m = 15;
  int ab_m  = 0;

  function automatic logic [7:0] mux_exp(bit js, bit ks, logic [3:0] jd, bit f, bit a, int k);
    logic [3:0] d;
    logic p;
    d = 4'hF;
    p = 1'b1;
    if (js) begin d = d & ~jd;       p = p & ~f; end
    if (ks) begin d = d & kc_tbl[k]; p = p & ~a; end
    return {3'b000, p, d};
  endfunction

  // Monitor: compare every expectation due this cycle, away from the active edge.
  logic [7:0] obs;
  always @(negedge clk) begin
    obs = {spin_busy, pin7_spa, pin9_spb, pin6_n, pin_data_n};
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at <= cyc) begin
        checks++;
        if (exp_q[i].at < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not evaluated (now %0d)",
                   exp_q[i].name, exp_q[i].at, cyc);
        end else if ((obs & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %h want %h (mask %h)",
                   exp_q[i].name, cyc, obs & exp_q[i].mask,
                   exp_q[i].val & exp_q[i].mask, exp_q[i].mask);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input string nm, input logic [7:0] v, input logic [7:0] m);
    exp_t e;
    e.at = at; e.name = nm; e.val = v; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic load_key(input int k);
    key_idx  = 4'(k);
    key_load = 1'b1;
    tick(1);
    key_load = 1'b0;
    key_m    = k;
  endtask

  task automatic spin_start(input int d, output int l);
    spin_delta = 8'(d);
    spin_load  = 1'b1;
    tick(1);
    spin_load  = 1'b0;
    l = cyc;
  endtask

  // Predict the first m steps of a run of d steps loaded on cycle l.
  task automatic spin_expect(input int l, input int d, input int m);
    int n;
    int dir;
    n   = (d < 0) ? -d : d;
    dir = (d < 0) ? -1 : 1;
    push(l, "spin_start", {(n != 0), ab_seq[ab_m], 5'b0}, 8'hE0);
    for (int i = 1; i <= m; i++) begin
      push(l + i * SD - 1, "spin_hold", {1'b1, ab_seq[ab_m], 5'b0}, 8'hE0);
      ab_m = (ab_m + dir + 4) % 4;
      push(l + i * SD, "spin_step", {(i < n), ab_seq[ab_m], 5'b0}, 8'hE0);
    end
  endtask

  initial begin
    int k;
    int l;
    int l2;
    int d;
    bit js, ks, f, a;
    logic [3:0] jd;

    // Reset: three clocks held, then two clocks released with selects idle
    push(1, "rst_hold", 8'h1F, 8'hFF);
    push(2, "rst_hold", 8'h1F, 8'hFF);
    push(3, "rst_hold", 8'h1F, 8'hFF);
    tick(3);
    rst = 1'b0;
    push(4, "rst_release", 8'h1F, 8'hFF);
    push(5, "rst_release", 8'h1F, 8'hFF);
    tick(3);

    // Joystick segment with exact strobe latency
    joy_dir = 4'b0101; fire_btn = 1'b1;
    tick(2);
    k = cyc;
    pin8_joy_sel_n = 1'b0;
    push(k + LAT - 1, "joy_pre", 8'h1F, 8'h1F);
    push(k + LAT, "joy_on", 8'h0A, 8'h1F);
    tick(LAT + 1);
    k = cyc;
    fire_btn = 1'b0;
    push(k + 1, "fire_release", 8'h1A, 8'h1F);
    tick(2);
    fire_btn = 1'b1;
    tick(2);
    k = cyc;
    pin8_joy_sel_n = 1'b1;
    push(k + LAT - 1, "joy_still", 8'h0A, 8'h1F);
    push(k + LAT, "joy_off", 8'h1F, 8'h1F);
    tick(LAT + 1);

    // Keypad sweep; key_idx wiggles without key_load to check the latch holds
    pin5_key_sel_n = 1'b0; arm_btn = 1'b1;
    tick(LAT + 1);
    for (int i = 0; i < 16; i++) begin
      load_key(i);
      key_idx = 4'($urandom);
      push(cyc + 1, "key_code", {4'b0000, kc_tbl[i]}, 8'h1F);
      push(cyc + 2, "key_hold", {4'b0000, kc_tbl[i]}, 8'h1F);
      tick(3);
    end

    // Both segments selected: wired-AND
    pin8_joy_sel_n = 1'b0; joy_dir = 4'b0001; fire_btn = 1'b0; arm_btn = 1'b1;
    load_key(8);
    tick(LAT + 1);
    push(cyc + 1, "both_sel", 8'h00, 8'h1F);
    tick(2);

    // Randomised segment selects, buttons and keys against the model
    for (int it = 0; it < 24; it++) begin
      js = 1'($urandom_range(0, 1));
      ks = 1'($urandom_range(0, 1));
      jd = 4'($urandom);
      f  = 1'($urandom_range(0, 1));
      a  = 1'($urandom_range(0, 1));
      pin8_joy_sel_n = ~js; pin5_key_sel_n = ~ks;
      joy_dir = jd; fire_btn = f; arm_btn = a;
      if ($urandom_range(0, 1) == 1) begin
        load_key(int'($urandom_range(0, 15)));
      end else begin
        tick(1);
      end
      key_idx = 4'($urandom);
      push(cyc + LAT - 1, "mux_rand", mux_exp(js, ks, jd, f, a, key_m), 8'h1F);
      tick(LAT + 1);
    end
    pin8_joy_sel_n = 1'b1; pin5_key_sel_n = 1'b1;
    tick(LAT + 1);

    // Spinner: +3 then -2
    spin_start(3, l);
    spin_expect(l, 3, 3);
    tick(3 * SD + 2);
    spin_start(-2, l);
    spin_expect(l, -2, 2);
    tick(2 * SD + 2);

    // Zero delta stays idle
    spin_start(0, l);
    spin_expect(l, 0, 0);
    push(l + SD, "spin_zero_idle", {1'b0, ab_seq[ab_m], 5'b0}, 8'hE0);
    tick(SD + 2);

    // Random short runs
    for (int it = 0; it < 4; it++) begin
      d = int'($urandom_range(0, 12)) - 6;
      spin_start(d, l);
      spin_expect(l, d, (d < 0) ? -d : d);
      tick(((d < 0) ? -d : d) * SD + 2);
    end

    // -128, reloaded with +1 mid-divider after 5 steps
    spin_start(-128, l);
    spin_expect(l, -128, 5);
    tick(5 * SD + 1);
    spin_start(1, l2);
    spin_expect(l2, 1, 1);
    push(l2 + 3 * SD, "spin_after_reload", {1'b0, ab_seq[ab_m], 5'b0}, 8'hE0);
    tick(3 * SD + 1);

    // Reset in the middle of a run
    spin_start(10, l);
    spin_expect(l, 10, 2);
    tick(2 * SD + 1);
    rst = 1'b1;
    push(cyc + 1, "rst_midrun", 8'h1F, 8'hFF);
    tick(1);
    rst = 1'b0;
    ab_m = 0;
    push(cyc + 2 * SD, "rst_quiet", 8'h00, 8'hE0);
    tick(2);

    for (int w = 0; w < 500 && exp_q.size() > 0; w++) tick(1);
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coleco_ctrl_port_emu.md
Name: coleco_ctrl_port_emu

Overview:
- Device-side emulator for one ColecoVision controller port: the responder to the console glue's controller-strobe and read cycles.
- Takes host-side button, keypad and spinner state and drives the active-low controller pins the glue samples.
- Provides joystick/keypad segment multiplexing, a keypad encoder and a quadrature spinner generator.
- Sits on the test/accessory board between a host-side bridge and one DE-9 controller connector; two instances cover both players.

Parameters:
- SPIN_DIV, 1000, clk cycles per spinner quadrature step (minimum 2).
- SYNC_STAGES, 2, synchroniser depth on the console strobe inputs (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pin5_key_sel_n  in  1  console keypad-segment common, active low
- pin8_joy_sel_n  in  1  console joystick-segment common, active low
- joy_dir  in  4  host joystick state {left,right,down,up}, active high
- fire_btn  in  1  host left/fire button, active high
- arm_btn  in  1  host right/arm button, active high
- key_idx  in  4  host keypad index: 0-9 digits, 10 '*', 11 '#', 12-15 none
- key_load  in  1  one-cycle strobe; latches key_idx
- spin_delta  in  8  signed spinner step count
- spin_load  in  1  one-cycle strobe; latches spin_delta
- pin_data_n  out  4  pins {4,3,2,1} to console, active low
- pin6_n  out  1  pin 6 (fire/arm), active low
- pin7_spa  out  1  spinner quadrature A
- pin9_spb  out  1  spinner quadrature B
- spin_busy  out  1  high while spinner steps remain

Behaviour:
- Reset values:
  - pin_data_n=4'hF, pin6_n=1, pin7_spa=0, pin9_spb=0, spin_busy=0.
  - Latched key = none; spinner remaining=0, phase=0, divider=0.
- Strobe sync: both select inputs pass through SYNC_STAGES flops. Synchroniser flops reset to 1 (deasserted).
- Output mux, registered one cycle after the synchronised selects:
  - joy_sel only: pin_data_n = ~joy_dir; pin6_n = ~fire_btn.
  - key_sel only: pin_data_n = keycode(latched key); pin6_n = ~arm_btn.
  - Both asserted: bitwise AND of the two segment values, matching wired-AND hardware.
  - Neither asserted: pin_data_n=4'hF, pin6_n=1.
- Latency: a strobe edge at the pin appears at the outputs SYNC_STAGES+1 clk later (3 with defaults). Host button changes appear 1 clk later.
- Keycode table (active-low nibble {p4,p3,p2,p1}):
  - 1=D, 2=7, 3=C, 4=2, 5=3, 6=E, 7=5, 8=1, 9=B, 0=A, *=9, #=6.
  - Indices 12-15 give F.
- key_load: key_idx is latched on that clk and used from the next cycle. Without key_load the latched key holds.
- Spinner FSM, states IDLE and STEP:
  - spin_load with nonzero delta: remaining=|delta|, dir=sign, divider=0, go to STEP, spin_busy=1 next cycle.
  - spin_load with zero delta: remaining=0, go to IDLE.
  - In STEP the divider counts 0..SPIN_DIV-1. At terminal count the phase advances and remaining decrements.
  - Positive direction, phase {A,B}: 00→10→11→01→00. Negative direction walks the reverse sequence.
  - When remaining reaches 0 after a step, go to IDLE and drop spin_busy the same cycle. The phase holds, so A/B are not returned to 00.
  - delta = -128 gives 128 steps; the magnitude is 8-bit unsigned.
  - spin_load while busy replaces remaining and dir and clears the divider. Phase continuity is preserved: no glitch step.
- Simultaneous key_load and spin_load: both are honoured independently.
- rst asserted mid-step: all state returns to reset values on the next clk edge and A/B go to 00.

Decomposition:
- Shared package coleco_ctrl_pkg:
  - keycode lookup constants (12 entries plus NONE=4'hF)
  - key index constants KEY_STAR=10, KEY_HASH=11
  - spinner state typedef {IDLE, STEP}
- One natural sub-module: coleco_spinner_quad, holding the divider, remaining counter, phase and FSM. Instantiated once.
- The synchroniser and output mux stay in the top module.

Test Plan:
- Reset: rst high 3 clk, selects idle → pin_data_n=F, pin6_n=1, A/B=00, spin_busy=0. Check the same values after release.
- Joystick: joy_dir=4'b0101, fire_btn=1, drop pin8_joy_sel_n → exactly 3 clk later pin_data_n=4'b1010, pin6_n=0. Raise the select → F/1 three clk later.
- Keypad sweep: for key_idx 0..15 pulse key_load, hold pin5_key_sel_n low → nibble follows the table (idx 0→A, 5→3, 10→9, 11→6, 12-15→F). arm_btn=1 → pin6_n=0.
- Both selects low: joy_dir=4'b0001, key 8 (code 1) → pin_data_n = ~0001 & 0001 = 0. Fire=0, arm=1 → pin6_n=0.
- Spinner: SPIN_DIV=4, spin_delta=+3 → A/B 10, 11, 01 at 4-clk spacing and spin_busy low after the 3rd step. Then spin_delta=-2 → 11, 10.
- Reload and reset: spin_delta=-128, reload +1 after 5 steps → exactly one further positive step. Separately, assert rst mid-run → A/B=00 and spin_busy=0 next clk.
